mem_channel_responder: RTL
==========================

// Module: mem_channel_responder
// PURPOSE
//  Synthesizable multi-channel memory responder for the GPU's valid/ready memory ports. Successor to the class-based bench memory.
//  Serves CHANNELS independent request channels against one shared storage array, with configurable read/write latency.
//  Sits opposite gpu.data_mem_* / gpu.program_mem_* in benches and FPGA bring-up; a load port preloads contents.
// PARAMETERS
//  ADDR_BITS      8   address width
//  DATA_BITS      8   word width
//  CHANNELS       4   independent request channels
//  READ_LATENCY   2   cycles from accepted read to read_ready (>=1)
//  WRITE_LATENCY  1   cycles from accepted write to write_ready (>=1)
//  JITTER_BITS    2   width of random extra latency (used only with jitter macro)
// PORTS
//  clk            in   1                    clock, all state on rising edge
//  reset          in   1                    asynchronous, active-low reset
//  load_en        in   1                    preload strobe
//  load_addr      in   ADDR_BITS            preload address
//  load_data      in   DATA_BITS            preload data
//  read_valid     in   [CHANNELS]           read request per channel
//  read_address   in   [CHANNELS][ADDR_BITS]
//  read_ready     out  [CHANNELS]           read response valid, data stable while high
//  read_data      out  [CHANNELS][DATA_BITS]
//  write_valid    in   [CHANNELS]           write request per channel
//  write_address  in   [CHANNELS][ADDR_BITS]
//  write_data     in   [CHANNELS][DATA_BITS]
//  write_ready    out  [CHANNELS]           write acknowledge
//  busy           out  1                    OR of all channels not IDLE
// BEHAVIOUR
//  - Reset (reset==0, async): read_ready=0, write_ready=0, read_data=0, busy=0, all channel FSMs IDLE, counters 0. Storage array NOT reset.
//  - Reset mid-transaction drops pending responses; no write commits after reset asserts.
//  - Per-channel FSM: IDLE -> RD_WAIT / WR_WAIT -> RD_RESP / WR_RESP -> IDLE.
//  - IDLE: write_valid sampled high takes priority over read_valid (-> WR_WAIT); otherwise read_valid (-> RD_WAIT). Address/data latched at acceptance edge.
//  - WAIT: down-counter loaded with LATENCY-1. At the edge where it reaches 0, FSM -> RESP and ready goes high.
//    Ready therefore rises exactly LATENCY edges after the acceptance edge.
//  - Read: read_data is sampled from the array at the edge read_ready rises, then held until the next read response.
//  - Write: the array is updated at the edge write_ready rises.
//  - RESP: ready is held high while valid stays high. At the edge valid is sampled low: ready->0 and FSM -> IDLE.
//    A new request is accepted at the following edge at the earliest.
//  - Valid drop during WAIT (protocol violation): the request completes anyway; ready pulses for 1 cycle.
//  - Same-edge write commits to one address from several channels: lowest channel index wins.
//  - Same-edge read sample and write commit to one address: the read returns the OLD data.
//  - Address wrap: addresses are ADDR_BITS wide, so there is no out-of-range access.
//  - load_en: writes load_data to load_addr at the edge, only when busy==0 and no channel accepts that edge. Otherwise it is ignored.
// CONFIGURATION
//  Macro MEM_RESPONDER_JITTER_EN:
//   defined: each channel adds 0..2**JITTER_BITS-1 extra WAIT cycles.
//     The extra count is taken from that channel's 8-bit LFSR (x^8+x^6+x^5+x^4+1), seeded with channel_index+1 at reset.
//     The LFSR steps every cycle out of reset and is sampled at the acceptance edge.
//   undefined: latency is exactly READ_LATENCY / WRITE_LATENCY; the LFSR is not instantiated.
// STRUCTURE
//  Package mem_responder_pkg: chan_state_e {IDLE,RD_WAIT,RD_RESP,WR_WAIT,WR_RESP}; LFSR_TAPS constant; function lat_load().
//  Sub-module mem_responder_channel: per-channel FSM, latency counter, optional LFSR.
//    Outputs: read-sample strobe, write-commit strobe, latched address/data.
//  Top: storage array, load port, write priority resolution (lowest channel wins), read muxing, busy OR. Channels come from a generate loop.
// TESTING
//  1. Preload addr 5=0x3C, ch0 read addr 5, READ_LATENCY=2 -> read_ready[0] rises 2 edges after acceptance, read_data[0]=0x3C; after valid drops, ready low next edge.
//  2. ch1 write addr 9=0xA5, then ch2 read addr 9 -> write_ready[1] after 1 edge; ch2 returns 0xA5.
//  3. ch0 and ch3 write addr 7 (0x11 / 0x22) accepted the same edge -> array[7]=0x11.
//  4. ch0 read addr 4 samples at the edge ch1 commits 0x77 to addr 4 (old 0x00) -> read_data[0]=0x00; a later read returns 0x77.
//  5. reset pulled low during RD_WAIT on all 4 channels -> all ready=0, busy=0 immediately; no stale ready after release.
//  6. load_en while busy=1 -> array unchanged; same load with busy=0 -> written. With MEM_RESPONDER_JITTER_EN: latency stays within [LAT, LAT+3].

Source files
------------

// File: rtl/mem_responder_pkg.sv
// +-----------------------------------------------------------------------------+
// | mem_responder_pkg : shared types and helpers for mem_channel_responder      |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } chan_state_e;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int LAT_BITS = 16;

  function automatic logic [LAT_BITS-1:0] lat_load(input int unsigned latency,
                                                   input logic [LAT_BITS-1:0] extra);
    return LAT_BITS'(latency - 1) + extra;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_channel_responder_if.sv
// +-----------------------------------------------------------------------------+
// | mem_channel_responder_if : per-channel read/write valid-ready bus bundle     |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface mem_channel_responder_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4
);

  logic [CHANNELS-1:0]                read_valid;
  logic [CHANNELS-1:0][ADDR_BITS-1:0] read_address;
  logic [CHANNELS-1:0]                read_ready;
  logic [CHANNELS-1:0][DATA_BITS-1:0] read_data;
  logic [CHANNELS-1:0]                write_valid;
  logic [CHANNELS-1:0][ADDR_BITS-1:0] write_address;
  logic [CHANNELS-1:0][DATA_BITS-1:0] write_data;
  logic [CHANNELS-1:0]                write_ready;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );

endinterface

`default_nettype wire

// File: rtl/mem_responder_channel.sv
// +-----------------------------------------------------------------------------+
// | mem_responder_channel : one request channel FSM with latency counter;       |
// | optional LFSR jitter under MEM_RESPONDER_JITTER_EN.  Revision 1.0           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_responder_channel #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int JITTER_BITS   = 2
`ifdef MEM_RESPONDER_JITTER_EN
  , parameter int CHAN_INDEX  = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 read_ready,
  output logic                 write_ready,
  output logic                 active,
  output logic                 accept,
  output logic                 read_sample,
  output logic                 write_commit,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] wdata
);
  import mem_responder_pkg::*;

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + (1 << JITTER_BITS)) + 1;

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] extra;

`ifdef MEM_RESPONDER_JITTER_EN
  localparam logic [7:0] JITTER_MASK = 8'((1 << JITTER_BITS) - 1);
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 8'(CHAN_INDEX + 1);
    else        lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign extra = CNT_W'(lfsr_q & JITTER_MASK);
`else
  assign extra = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // write wins over a simultaneous read request
        if (write_valid) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_W'(lat_load(WRITE_LATENCY, LAT_BITS'(extra)));
        end else if (read_valid) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(lat_load(READ_LATENCY, LAT_BITS'(extra)));
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = WR_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RD_RESP: if (!read_valid)  state_d = IDLE;
      WR_RESP: if (!write_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr    <= '0;
      wdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && write_valid) begin
        addr  <= write_address;
        wdata <= write_data;
      end else if (state_q == IDLE && read_valid) begin
        addr  <= read_address;
      end
    end
  end

  assign read_ready   = (state_q == RD_RESP);
  assign write_ready  = (state_q == WR_RESP);
  assign active       = (state_q != IDLE);
  assign accept       = (state_q == IDLE) && (read_valid || write_valid);
  assign read_sample  = (state_q == RD_WAIT) && (cnt_q == '0);
  assign write_commit = (state_q == WR_WAIT) && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_channel_responder.sv
// +-----------------------------------------------------------------------------+
// | mem_channel_responder : multi-channel valid/ready memory with shared array; |
// | MEM_RESPONDER_JITTER_EN adds random per-channel latency.  Revision 1.0      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_channel_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int CHANNELS      = 4,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int JITTER_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [ADDR_BITS-1:0]   load_addr,
  input  logic [DATA_BITS-1:0]   load_data,
  mem_channel_responder_if.slave bus,
  output logic                   busy
);
  import mem_responder_pkg::*;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  logic [CHANNELS-1:0]  rd_ready, wr_ready, active, accept, rd_sample, wr_commit, wr_grant;
  logic [ADDR_BITS-1:0] ch_addr   [CHANNELS];
  logic [DATA_BITS-1:0] ch_wdata  [CHANNELS];
  logic [DATA_BITS-1:0] rd_data_q [CHANNELS];
  logic                 load_ok;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    mem_responder_channel #(
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS),
      .READ_LATENCY (READ_LATENCY),
      .WRITE_LATENCY(WRITE_LATENCY),
      .JITTER_BITS  (JITTER_BITS)
`ifdef MEM_RESPONDER_JITTER_EN
      , .CHAN_INDEX (g)
`endif
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .read_valid   (bus.read_valid[g]),
      .read_address (bus.read_address[g]),
      .write_valid  (bus.write_valid[g]),
      .write_address(bus.write_address[g]),
      .write_data   (bus.write_data[g]),
      .read_ready   (rd_ready[g]),
      .write_ready  (wr_ready[g]),
      .active       (active[g]),
      .accept       (accept[g]),
      .read_sample  (rd_sample[g]),
      .write_commit (wr_commit[g]),
      .addr         (ch_addr[g]),
      .wdata        (ch_wdata[g])
    );

    assign bus.read_data[g] = rd_data_q[g];
  end

  assign bus.read_ready  = rd_ready;
  assign bus.write_ready = wr_ready;
  assign busy            = |active;
  assign load_ok         = load_en && !busy && !(|accept);

  // A commit is dropped if any lower-indexed channel commits to the same address
  always_comb begin
    wr_grant = wr_commit;
    for (int i = 1; i < CHANNELS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (wr_commit[j] && (ch_addr[j] == ch_addr[i])) wr_grant[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) mem[load_addr] <= load_data;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_grant[i]) mem[ch_addr[i]] <= ch_wdata[i];
    end
  end

  // Non-blocking update means a same-edge commit is not visible to this sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) rd_data_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rd_sample[i]) rd_data_q[i] <= mem[ch_addr[i]];
      end
    end
  end

endmodule

`default_nettype wire
